// File: rtl/ssr_seq_if.sv
// rtl/ssr_seq_if.sv - command and SSR-port bundle between the control path, ssr_seq and the SSR
interface ssr_seq_if #(
  parameter int WIDTH = 64,
  parameter int IW    = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [IW-1:0]    cmd_arg;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] ssr_q;
  logic [2:0]       ssr_s;
  logic [IW-1:0]    ssr_ii;
  logic [WIDTH-1:0] ssr_d;
  logic             done;
  logic [IW-1:0]    shift_cnt;
  logic             norm_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_data, ssr_q,
    input  cmd_ready, ssr_s, ssr_ii, ssr_d, done, shift_cnt, norm_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_data, ssr_q,
    output cmd_ready, ssr_s, ssr_ii, ssr_d, done, shift_cnt, norm_zero
  );
endinterface

// File: rtl/ssr_seq.sv
// rtl/ssr_seq.sv - expands load/shift/bit/normalize commands into per-cycle SSR opcodes
module ssr_seq #(
  parameter int WIDTH = 64,
  parameter int IW    = 6
) (
  input  logic    clk,
  input  logic    rst,
  ssr_seq_if.slave bus
);
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_SET  = 3'b101;
  localparam logic [2:0] OP_NORM = 3'b110;

  localparam logic [2:0] S_HOLD = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_LSH  = 3'b010;
  localparam logic [2:0] S_RSH  = 3'b011;
  localparam logic [2:0] S_CLR  = 3'b100;
  localparam logic [2:0] S_SET  = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC1, SHIFT, NORM} state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    arg_q;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    ii_q;
  logic [IW-1:0]    shift_cnt_q;
  logic             norm_zero_q;
  logic             done_q;

  logic             norm_shift;
  logic [IW-1:0]    cnt_inc;
  logic [2:0]       ssr_s_d;

  // Normalize keeps shifting while the value is non-zero and its MSB is still clear.
  assign norm_shift = (bus.ssr_q != '0) && !bus.ssr_q[WIDTH-1];
  assign cnt_inc    = shift_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'b000;
      arg_q       <= '0;
      data_q      <= '0;
      ii_q        <= '0;
      shift_cnt_q <= '0;
      norm_zero_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            arg_q       <= bus.cmd_arg;
            data_q      <= bus.cmd_data;
            ii_q        <= (bus.cmd_op == OP_SET || bus.cmd_op == OP_CLR) ? bus.cmd_arg : '0;
            shift_cnt_q <= '0;
            if (bus.cmd_op != OP_NORM) norm_zero_q <= 1'b0;
            case (bus.cmd_op)
              OP_LOAD, OP_SET, OP_CLR: state_q <= EXEC1;
              OP_SHL, OP_SHR: begin
                if (bus.cmd_arg == '0) done_q  <= 1'b1;
                else                   state_q <= SHIFT;
              end
              OP_NORM: state_q <= NORM;
              default: done_q  <= 1'b1;
            endcase
          end
        end
        EXEC1: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        SHIFT: begin
          shift_cnt_q <= cnt_inc;
          if (cnt_inc == arg_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        NORM: begin
          if (norm_shift) begin
            shift_cnt_q <= cnt_inc;
          end else begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            norm_zero_q <= (bus.ssr_q == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ssr_s_d = S_HOLD;
    case (state_q)
      EXEC1: begin
        case (op_q)
          OP_LOAD: ssr_s_d = S_LOAD;
          OP_SET:  ssr_s_d = S_SET;
          OP_CLR:  ssr_s_d = S_CLR;
          default: ssr_s_d = S_HOLD;
        endcase
      end
      SHIFT:   ssr_s_d = (op_q == OP_SHR) ? S_RSH : S_LSH;
      NORM:    ssr_s_d = norm_shift ? S_LSH : S_HOLD;
      default: ssr_s_d = S_HOLD;
    endcase
  end

  assign bus.ssr_s     = ssr_s_d;
  assign bus.ssr_ii    = ii_q;
  assign bus.ssr_d     = data_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.shift_cnt = shift_cnt_q;
  assign bus.norm_zero = norm_zero_q;
endmodule

// File: tb/tb_ssr_seq.sv
// tb/tb_ssr_seq.sv - ssr_seq driving a behavioural SSR, checked against an arithmetic command model
module tb_ssr_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ssr_reg = '0;
  logic [63:0] exp_reg = '0;
  int          checks = 0;
  int          failures = 0;

  ssr_seq_if #(.WIDTH(64), .IW(6)) bus ();

  ssr_seq #(.WIDTH(64), .IW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 64-bit SSR: applies whatever opcode the sequencer presents at each edge.
  assign bus.ssr_q = ssr_reg;
  always @(posedge clk) begin
    case (bus.ssr_s)
      3'b001: ssr_reg <= bus.ssr_d;
      3'b010: ssr_reg <= ssr_reg << 1;
      3'b011: ssr_reg <= ssr_reg >> 1;
      3'b100: ssr_reg <= ssr_reg & ~(64'd1 << bus.ssr_ii);
      3'b101: ssr_reg <= ssr_reg | (64'd1 << bus.ssr_ii);
      default: ssr_reg <= ssr_reg;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [5:0] arg, input logic [63:0] data);
    logic [63:0] v, nxt, tmp;
    int lat, act, cnt, nz, code, n, act_seen, s_bad, ii_bad, rdy_bad;
    v = exp_reg; nxt = v; lat = 0; act = 0; cnt = 0; nz = 0; code = 0;
    case (op)
      3'd1: begin nxt = data; lat = 1; act = 1; code = 1; end
      3'd2: begin nxt = v << arg; lat = int'(arg); act = int'(arg); cnt = int'(arg); code = 2; end
      3'd3: begin nxt = v >> arg; lat = int'(arg); act = int'(arg); cnt = int'(arg); code = 3; end
      3'd4: begin nxt = v & ~(64'd1 << arg); lat = 1; act = 1; code = 4; end
      3'd5: begin nxt = v | (64'd1 << arg); lat = 1; act = 1; code = 5; end
      3'd6: begin
        code = 2;
        if (v == 0) begin
          nz = 1; lat = 1;
        end else begin
          tmp = v;
          while (!tmp[63]) begin tmp = tmp << 1; cnt++; end
          nxt = tmp; act = cnt; lat = cnt + 1;
        end
      end
      default: ;
    endcase
    @(negedge clk);
    check("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg; bus.cmd_data = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'($urandom); bus.cmd_arg = 6'($urandom); bus.cmd_data = {$urandom, $urandom};
    n = 0; act_seen = 0; s_bad = 0; ii_bad = 0; rdy_bad = 0;
    while (n < 300) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.cmd_ready) rdy_bad++;
      if (bus.ssr_s != 0) begin
        act_seen++;
        if (int'(bus.ssr_s) != code) s_bad++;
        if ((op == 3'd4 || op == 3'd5) && bus.ssr_ii != arg) ii_bad++;
      end
      n++;
    end
    check($sformatf("latency op%0d", op), 64'(n), 64'(lat));
    check($sformatf("active_cycles op%0d", op), 64'(act_seen), 64'(act));
    check($sformatf("opcode_errs op%0d", op), 64'(s_bad + ii_bad + rdy_bad), 0);
    check($sformatf("ssr_q op%0d", op), ssr_reg, nxt);
    check($sformatf("shift_cnt op%0d", op), 64'(bus.shift_cnt), 64'(cnt));
    check($sformatf("norm_zero op%0d", op), 64'(bus.norm_zero), 64'(nz));
    check($sformatf("ready_at_done op%0d", op), {bus.cmd_ready, bus.ssr_s}, 4'b1000);
    check($sformatf("ssr_d op%0d", op), bus.ssr_d, data);
    @(negedge clk);
    check($sformatf("done_one_cycle op%0d", op), 64'(bus.done), 0);
    exp_reg = nxt;
  endtask

  initial begin
    logic [63:0] prev;
    int dseen;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_arg = '0; bus.cmd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {bus.ssr_s, bus.ssr_ii, bus.done, bus.shift_cnt, bus.norm_zero, bus.cmd_ready},
          {3'b000, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1});
    check("reset_ssr_d", bus.ssr_d, 0);

    run_cmd(3'd1, 6'd0, 64'h0000_0000_0000_00F0);
    check("t1_q", ssr_reg, 64'hF0);
    run_cmd(3'd2, 6'd4, 64'd0);
    check("t2_q", ssr_reg, 64'hF00);
    run_cmd(3'd3, 6'd0, 64'd0);
    run_cmd(3'd6, 6'd0, 64'd0);
    check("t3_q", ssr_reg, 64'hF000_0000_0000_0000);
    check("t3_cnt", 64'(bus.shift_cnt), 52);
    run_cmd(3'd1, 6'd0, 64'h8000_0000_0000_0000);
    run_cmd(3'd6, 6'd0, 64'd0);
    run_cmd(3'd1, 6'd0, 64'd0);
    run_cmd(3'd6, 6'd0, 64'd0);
    check("t4_zero", 64'(bus.norm_zero), 1);
    run_cmd(3'd1, 6'd0, 64'h0F);

    // SET then CLR with cmd_valid held: second accept lands on the first done edge.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd5; bus.cmd_arg = 6'd63;
    @(posedge clk);
    #1 bus.cmd_op = 3'd4; bus.cmd_arg = 6'd0;
    @(negedge clk);
    check("b2b_set", {bus.ssr_s, bus.ssr_ii, bus.cmd_ready}, {3'b101, 6'd63, 1'b0});
    @(negedge clk);
    check("b2b_done1", {bus.done, bus.cmd_ready}, 2'b11);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_clr", {bus.ssr_s, bus.ssr_ii, bus.cmd_ready}, {3'b100, 6'd0, 1'b0});
    @(negedge clk);
    check("b2b_done2", 64'(bus.done), 1);
    check("b2b_q", ssr_reg, 64'h8000_0000_0000_000E);
    exp_reg = 64'h8000_0000_0000_000E;
    run_cmd(3'd7, 6'd5, 64'd0);
    check("reserved_q", ssr_reg, 64'h8000_0000_0000_000E);

    // Reset sampled on the 10th shift edge of a 40-bit shift.
    run_cmd(3'd1, 6'd0, 64'h0000_0123_4567_89AB);
    prev = exp_reg;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_arg = 6'd40;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {bus.ssr_s, bus.cmd_ready, bus.shift_cnt, bus.done, bus.norm_zero},
          {3'b000, 1'b1, 6'd0, 1'b0, 1'b0});
    dseen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.ssr_s != 0) dseen++;
    end
    check("rst_mid_no_done", 64'(dseen), 0);
    check("rst_mid_q", ssr_reg, prev << 10);
    exp_reg = prev << 10;

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [5:0]  arg;
      logic [63:0] data;
      op   = 3'($urandom_range(0, 7));
      arg  = (op == 3'd2 || op == 3'd3) ? 6'($urandom_range(0, 20)) : 6'($urandom);
      data = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) data = '0;
      run_cmd(op, arg, data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
